// File: rtl/sll_pkg.sv
// Shared constants and types for the sequential left-shift unit.
//   XLEN    : operand/result width (fixed at 64)
//   SHAMT_W : shift-amount width, log2(XLEN)
//   state_t : controller states IDLE / BUSY / DONE
package sll_pkg;
  localparam int XLEN    = 64;
  localparam int SHAMT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/sll_step.sv
// One-position logical left shift with zero fill.
//   d : value in
//   q : d shifted left by one; bit XLEN-1 of d is discarded
module sll_step
  import sll_pkg::*;
(
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);
  assign q = {d[XLEN-2:0], 1'b0};
endmodule

// File: rtl/shift_left_logical_seq.sv
// Sequential logical-left-shift unit (SLL/SLLI, optionally SLLW/SLLIW).
// Shifts one bit per clock; latency from accept edge to out_valid is shamt+1.
// Optional feature macro: SLL_WORD_EN (adds is_word port, word-mode result).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready only in IDLE)
//   a, shamt            : operand and 6-bit shift amount
//   is_word             : word operation select (SLL_WORD_EN only)
//   out_valid/out_ready : result handshake (out_valid only in DONE)
//   result              : shifted value, from registers only
module shift_left_logical_seq
  import sll_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    a,
  input  logic [SHAMT_W-1:0] shamt,
`ifdef SLL_WORD_EN
  input  logic               is_word,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    result
);

  state_t             state_q;
  logic [XLEN-1:0]    data_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [XLEN-1:0]    data_shl;

`ifdef SLL_WORD_EN
  logic word_q;
`endif

  sll_step u_step (
    .d (data_q),
    .q (data_shl)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
`ifdef SLL_WORD_EN
      word_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q  <= a;
`ifdef SLL_WORD_EN
            word_q  <= is_word;
            // word shifts only use the low five amount bits
            cnt_q   <= is_word ? {1'b0, shamt[SHAMT_W-2:0]} : shamt;
`else
            cnt_q   <= shamt;
`endif
            state_q <= BUSY;
          end
        end
        BUSY: begin
          // the zero-count cycle is the extra edge giving shamt+1 latency
          if (cnt_q == '0) begin
            state_q <= DONE;
          end else begin
            data_q <= data_shl;
            cnt_q  <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

`ifdef SLL_WORD_EN
  assign result = word_q ? {{32{data_q[31]}}, data_q[31:0]} : data_q;
`else
  assign result = data_q;
`endif

endmodule

// File: tb/tb_shift_left_logical_seq.sv
// Scoreboard bench for shift_left_logical_seq: the driver pushes expected
// result and latency on each accepted operand, the monitor pops on each
// result handshake and compares.
module tb_shift_left_logical_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = '0;
  logic [5:0]  shamt = '0;
  logic        is_word = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];

  shift_left_logical_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .shamt     (shamt),
`ifdef SLL_WORD_EN
    .is_word   (is_word),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: pops one expectation per result handshake
  logic prev_v = 1'b0;
  int   rise_cyc = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) rise_cyc = cyc;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got result %h with no pending op", result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("latency", 64'(rise_cyc - e.acc), 64'(e.lat));
        end
      end
      prev_v = out_valid;
    end
  end

  // drive one operand and wait (bounded) for acceptance
  task automatic send(input logic [63:0] av, input logic [5:0] sh, input logic w,
                      input logic [63:0] exp_res, input int exp_lat, input bit push);
    bit ok = 0;
    @(negedge clk);
    in_valid = 1'b1; a = av; shamt = sh; is_word = w;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (in_ready) ok = 1;
      @(posedge clk);
      if (!ok) @(negedge clk);
    end
    #1;
    in_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
    end else if (push) begin
      sb.push_back('{exp_res, exp_lat, cyc});
    end
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // zero shift
    send(64'h1234_5678_9ABC_DEF0, 6'd0, 1'b0, 64'h1234_5678_9ABC_DEF0, 1, 1);
    drain(100);

    // ordinary shifts
    send(64'h0000_0000_0000_00FF, 6'd8, 1'b0, 64'h0000_0000_0000_FF00, 9, 1);
    drain(100);
    send(64'h8000_0000_0000_0001, 6'd1, 1'b0, 64'h0000_0000_0000_0002, 2, 1);
    drain(100);

    // maximum shift: upper set bit discarded
    send(64'h0000_0000_0000_0003, 6'd63, 1'b0, 64'h8000_0000_0000_0000, 64, 1);
    drain(200);

    // backpressure
    out_ready = 1'b0;
    send(64'h1, 6'd4, 1'b0, 64'h10, 5, 1);
    for (int i = 0; i < 50 && !out_valid; i++) @(posedge clk);
    #1;
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_result", result, 64'h10);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_back_idle", 64'(in_ready), 64'd1);
    drain(20);

    // busy rejection
    send(64'h1, 6'd8, 1'b0, 64'h100, 9, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1; a = 64'hAA; shamt = 6'd1;
    @(posedge clk); #1;
    chk("busy_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    drain(100);

`ifdef SLL_WORD_EN
    // word mode: shamt[5] ignored, sign-extended low word
    send(64'h0000_0000_4000_0001, 6'd33, 1'b1, 64'hFFFF_FFFF_8000_0002, 2, 1);
    drain(100);
`endif

    // reset mid-BUSY drops the operation
    send(64'hFFFF_FFFF_FFFF_FFFF, 6'd40, 1'b0, 64'h0, 0, 0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 70; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("midrst_no_done", 64'(seen), 64'd0);
    end

    // operation after reset still works
    send(64'h0000_0000_0000_0005, 6'd2, 1'b0, 64'h0000_0000_0000_0014, 3, 1);
    drain(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end
endmodule

// File: doc/shift_left_logical_seq.md
# shift_left_logical_seq

Sequential logical-left-shift unit for the RV64 execute stage: the left-shift counterpart to the combinational right-shift path. It accepts a 64-bit operand and a 6-bit shift amount through a valid/ready handshake. It shifts one bit position per clock and returns the registered result through a second valid/ready handshake. It serves SLL/SLLI, and SLLW/SLLIW when configured, wherever a multi-cycle shift is acceptable in exchange for area.

## Interface
- XLEN, 64: operand and result width; fixed at 64.
- SHAMT_W, 6: shift-amount width, log2(XLEN).
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high; clears all state
- in_valid  input  1  operand presented
- in_ready  output  1  unit can accept an operand; high only in IDLE
- a  input  64  operand to shift
- shamt  input  6  shift amount, 0..63
- is_word  input  1  selects word (W) operation; exists only with SLL_WORD_EN
- out_valid  output  1  result valid; high only in DONE
- out_ready  input  1  consumer accepts the result
- result  output  64  shifted value; registered

## Operation
- States: IDLE, BUSY, DONE. The state is held in an encoded register.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: load data_q←a and cnt_q←shamt, then go to BUSY.
- BUSY:
  - If cnt_q==0: go to DONE.
  - Otherwise: data_q←{data_q[62:0],1'b0} and cnt_q←cnt_q−1.
- DONE:
  - out_valid=1 and result=data_q, held stable until accepted.
  - On out_ready: go to IDLE.
- Arithmetic:
  - Shift amounts are taken modulo 64, because shamt is only 6 bits.
  - Bits shifted past bit 63 are discarded. Zero-fill comes in from bit 0.
- Inputs outside IDLE: in_valid is ignored; no operand is captured.
- Simultaneous events:
  - out_ready in DONE and a new in_valid on the same edge: only the hand-back occurs. The new operand is accepted at the following edge, because in_ready is low in DONE.
  - out_ready is ignored outside DONE.
- Reset, at any time including mid-shift:
  - state=IDLE, data_q=0, cnt_q=0.
  - Outputs: in_ready=1, out_valid=0, result=0.
  - The in-flight operation is dropped. No out_valid pulse is produced for it.

## Timing
- Latency is counted in clock edges from the accepting edge to the edge where out_valid rises: shamt+1.
  - shamt=0 gives out_valid one cycle after acceptance.
  - shamt=63 gives out_valid 64 cycles after acceptance.
- Throughput: one operation per shamt+3 cycles when out_ready is held high.
  - The breakdown is accept, shamt+1 edges to DONE, one DONE cycle, then a return to IDLE.
- All outputs are driven from registers or from the state decode only. There is no combinational path from inputs to outputs.

## Configuration
- Macro: SLL_WORD_EN.
- Defined:
  - The is_word port exists and is captured in IDLE alongside a.
  - When is_word=1:
    - shamt[5] is ignored at capture, so cnt_q←{1'b0,shamt[4:0]}.
    - In DONE, result={{32{data_q[31]}},data_q[31:0]}, the sign-extended low word.
  - Latency is shamt[4:0]+1.
- Undefined:
  - No is_word port.
  - The full 6-bit shamt is always used, and result=data_q.

## Structure
- Shared package sll_pkg holds:
  - XLEN=64 and SHAMT_W=6 constants.
  - The state typedef {IDLE, BUSY, DONE}.
- One natural sub-module: sll_step, a combinational 64-bit one-position left shift with zero fill. It is instantiated once in the BUSY datapath.

## Test plan
- Reset mid-BUSY:
  - Stimulus: a=64'hFFFF_FFFF_FFFF_FFFF, shamt=40; assert rst 10 cycles after acceptance.
  - Required: out_valid=0, in_ready=1, result=0 immediately; no DONE afterwards.
- Zero shift:
  - Stimulus: a=64'h1234_5678_9ABC_DEF0, shamt=0.
  - Required: out_valid one cycle after acceptance with result=64'h1234_5678_9ABC_DEF0.
- Maximum shift:
  - Stimulus: a=64'h0000_0000_0000_0003, shamt=63.
  - Required: result=64'h8000_0000_0000_0000 exactly 64 cycles after acceptance. The upper set bit is discarded.
- Backpressure:
  - Stimulus: a=64'h1, shamt=4; hold out_ready=0 for 5 cycles in DONE.
  - Required: result=64'h10 stable and in_ready=0 throughout. Returns to IDLE one edge after out_ready=1.
- Busy rejection:
  - Stimulus: pulse in_valid with a=64'hAA, shamt=1 while BUSY on a prior a=64'h1, shamt=8.
  - Required: result=64'h100. The second operand is not captured.
- SLL_WORD_EN:
  - Stimulus: a=64'h0000_0000_4000_0001, shamt=6'd33, is_word=1.
  - Required: shift by 1, result=64'hFFFF_FFFF_8000_0002, out_valid 2 cycles after acceptance.
